gpr_snapshot_reader: RTL and testbench



---
 rtl/gpr_snapshot_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_gpr_snapshot_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_snapshot_reader.sv
// rtl/gpr_snapshot_reader.sv - streams 32 GPRs plus committed PC as indexed beats per snapshot request
// Optional CSR beats (idx 33..36) are enabled by defining GPR_SNAP_CSR_EN.
module gpr_snapshot_reader #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snap_req,
    input  logic [XLEN-1:0]   snap_pc,
`ifdef GPR_SNAP_CSR_EN
    input  logic [XLEN-1:0]   csr_mstatus,
    input  logic [XLEN-1:0]   csr_mepc,
    input  logic [XLEN-1:0]   csr_mcause,
    input  logic [XLEN-1:0]   csr_mtvec,
`endif
    output logic              busy,
    output logic              rf_ren,
    output logic [4:0]        rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_idx,
    output logic [XLEN-1:0]   out_data,
    output logic              out_last,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_PCB,
`ifdef GPR_SNAP_CSR_EN
        S_CSR,
`endif
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        rd_idx_q, rd_idx_d;
    logic [4:0]        last_addr_q, last_addr_d;
    logic              inf_q;
    logic [4:0]        inf_idx_q;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [5:0]        f_idx_q  [2];
    logic [5:0]        f_idx_d  [2];
    logic [XLEN-1:0]   f_data_q [2];
    logic [XLEN-1:0]   f_data_d [2];
    logic              f_last_q [2];
    logic              f_last_d [2];
    logic [DROP_W-1:0] drop_q, drop_d;
`ifdef GPR_SNAP_CSR_EN
    logic [XLEN-1:0]   csr_q [4];
    logic [XLEN-1:0]   csr_d [4];
    logic [1:0]        csr_sel_q, csr_sel_d;
`endif

    logic              pop;
    logic              room_ok;
    logic              push_b;
    logic [5:0]        b_idx;
    logic [XLEN-1:0]   b_data;
    logic              b_last;
    logic [1:0]        fill;

    // A slot is claimed at issue time, so a read only goes out if its data is guaranteed a place.
    assign pop      = (cnt_q != 2'd0) && out_ready;
    assign room_ok  = (({1'b0, cnt_q} + {2'b0, inf_q} - {2'b0, pop}) < 3'd2);
    assign rf_ren   = (state_q == S_RD) && room_ok;
    assign rf_raddr = rf_ren ? rd_idx_q : last_addr_q;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (cnt_q != 2'd0);
    assign out_idx   = f_idx_q[0];
    assign out_data  = f_data_q[0];
    assign out_last  = f_last_q[0];
    assign drop_cnt  = drop_q;

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        last_addr_d = rf_ren ? rd_idx_q : last_addr_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        push_b      = 1'b0;
        b_idx       = 6'd0;
        b_data      = '0;
        b_last      = 1'b0;
`ifdef GPR_SNAP_CSR_EN
        csr_d       = csr_q;
        csr_sel_d   = csr_sel_q;
`endif
        if (snap_req && (state_q != S_IDLE) && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    state_d  = S_RD;
                    rd_idx_d = 5'd0;
                    pc_d     = snap_pc;
`ifdef GPR_SNAP_CSR_EN
                    csr_d[0] = csr_mstatus;
                    csr_d[1] = csr_mepc;
                    csr_d[2] = csr_mcause;
                    csr_d[3] = csr_mtvec;
`endif
                end
            end
            S_RD: begin
                if (room_ok) begin
                    rd_idx_d = rd_idx_q + 5'd1;
                    if (rd_idx_q == 5'(NREG - 1)) begin
                        state_d = S_PCB;
                    end
                end
            end
            S_PCB: begin
                if (room_ok) begin
                    push_b = 1'b1;
                    b_idx  = 6'd32;
                    b_data = pc_q;
`ifdef GPR_SNAP_CSR_EN
                    b_last    = 1'b0;
                    csr_sel_d = 2'd0;
                    state_d   = S_CSR;
`else
                    b_last  = 1'b1;
                    state_d = S_DRAIN;
`endif
                end
            end
`ifdef GPR_SNAP_CSR_EN
            S_CSR: begin
                if (room_ok) begin
                    push_b    = 1'b1;
                    b_idx     = 6'd33 + {4'd0, csr_sel_q};
                    b_data    = csr_q[csr_sel_q];
                    b_last    = (csr_sel_q == 2'd3);
                    csr_sel_d = csr_sel_q + 2'd1;
                    if (csr_sel_q == 2'd3) begin
                        state_d = S_DRAIN;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Returning read data enters ahead of a same-cycle PC/CSR push to keep beat order.
    always_comb begin
        f_idx_d  = f_idx_q;
        f_data_d = f_data_q;
        f_last_d = f_last_q;
        fill     = cnt_q;
        if (pop) begin
            f_idx_d[0]  = f_idx_q[1];
            f_data_d[0] = f_data_q[1];
            f_last_d[0] = f_last_q[1];
            fill        = fill - 2'd1;
        end
        if (inf_q) begin
            f_idx_d[fill[0]]  = {1'b0, inf_idx_q};
            f_data_d[fill[0]] = (inf_idx_q == 5'd0) ? '0 : rf_rdata;
            f_last_d[fill[0]] = 1'b0;
            fill              = fill + 2'd1;
        end
        if (push_b) begin
            f_idx_d[fill[0]]  = b_idx;
            f_data_d[fill[0]] = b_data;
            f_last_d[fill[0]] = b_last;
            fill              = fill + 2'd1;
        end
        cnt_d = fill;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_idx_q    <= 5'd0;
            last_addr_q <= 5'd0;
            inf_q       <= 1'b0;
            inf_idx_q   <= 5'd0;
            pc_q        <= '0;
            cnt_q       <= 2'd0;
            drop_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                f_idx_q[i]  <= 6'd0;
                f_data_q[i] <= '0;
                f_last_q[i] <= 1'b0;
            end
`ifdef GPR_SNAP_CSR_EN
            for (int i = 0; i < 4; i++) begin
                csr_q[i] <= '0;
            end
            csr_sel_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            last_addr_q <= last_addr_d;
            inf_q       <= rf_ren;
            inf_idx_q   <= rd_idx_q;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            f_idx_q     <= f_idx_d;
            f_data_q    <= f_data_d;
            f_last_q    <= f_last_d;
`ifdef GPR_SNAP_CSR_EN
            csr_q       <= csr_d;
            csr_sel_q   <= csr_sel_d;
`endif
        end
    end

endmodule

// File: tb/tb_gpr_snapshot_reader.sv
// tb/tb_gpr_snapshot_reader.sv - scoreboard bench for gpr_snapshot_reader
module tb_gpr_snapshot_reader;
    localparam int XLEN = 64;

    typedef struct packed {
        logic [5:0]      idx;
        logic [XLEN-1:0] data;
        logic            last;
    } beat_t;

    logic            clk;
    logic            rst_n;
    logic            snap_req;
    logic [XLEN-1:0] snap_pc;
    logic            busy;
    logic            rf_ren;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_idx;
    logic [XLEN-1:0] out_data;
    logic            out_last;
    logic [15:0]     drop_cnt;
`ifdef GPR_SNAP_CSR_EN
    logic [XLEN-1:0] csr_mstatus = 64'h0000_0000_0000_1800;
    logic [XLEN-1:0] csr_mepc    = 64'h0000_0000_8000_0200;
    logic [XLEN-1:0] csr_mcause  = 64'h0000_0000_0000_000B;
    logic [XLEN-1:0] csr_mtvec   = 64'h0000_0000_8000_0100;
`endif

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    c0 = 0;
    int    ren_cnt = 0;
    int    hs_cnt = 0;
    int    max_out = 0;
    int    first_cyc = -1;
    int    last_cyc = -1;
    logic  stall_q = 1'b0;
    beat_t hold;
    beat_t cur;
    beat_t e;
    beat_t exp_q[$];
    logic [XLEN-1:0] rf [32];

    gpr_snapshot_reader #(.XLEN(XLEN), .NREG(32), .DROP_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .snap_req(snap_req),
        .snap_pc(snap_pc),
`ifdef GPR_SNAP_CSR_EN
        .csr_mstatus(csr_mstatus),
        .csr_mepc(csr_mepc),
        .csr_mcause(csr_mcause),
        .csr_mtvec(csr_mtvec),
`endif
        .busy(busy),
        .rf_ren(rf_ren),
        .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx(out_idx),
        .out_data(out_data),
        .out_last(out_last),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read register file model.
    initial begin
        rf[0] = 64'hDEAD;
        for (int i = 1; i < 32; i++) rf[i] = 64'h1000 + i;
        rf_rdata = '0;
    end
    always @(posedge clk) if (rf_ren) rf_rdata <= rf[rf_raddr];

    always @(negedge clk) begin
        cur = {out_idx, out_data, out_last};
        if (rf_ren) ren_cnt++;
        if (stall_q) begin
            checks++;
            if (out_valid !== 1'b1 || cur !== hold) begin
                errors++;
                $display("FAIL stall_hold: valid=%b idx=%0d data=%h last=%b required valid=1 idx=%0d data=%h last=%b",
                         out_valid, out_idx, out_data, out_last, hold.idx, hold.data, hold.last);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: idx=%0d data=%h required no beat", out_idx, out_data);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL beat: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             out_idx, out_data, out_last, e.idx, e.data, e.last);
                end
                if (e.idx == 6'd0) first_cyc = cyc;
                if (e.last) last_cyc = cyc;
            end
        end
        if (ren_cnt - hs_cnt > max_out) max_out = ren_cnt - hs_cnt;
        stall_q = out_valid && !out_ready;
        hold = cur;
    end

    task automatic exp_burst(input logic [XLEN-1:0] pc);
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.idx  = 6'(i);
            b.data = (i == 0) ? '0 : 64'h1000 + i;
            b.last = 1'b0;
            exp_q.push_back(b);
        end
`ifdef GPR_SNAP_CSR_EN
        exp_q.push_back({6'd32, pc, 1'b0});
        exp_q.push_back({6'd33, csr_mstatus, 1'b0});
        exp_q.push_back({6'd34, csr_mepc, 1'b0});
        exp_q.push_back({6'd35, csr_mcause, 1'b0});
        exp_q.push_back({6'd36, csr_mtvec, 1'b1});
`else
        exp_q.push_back({6'd32, pc, 1'b1});
`endif
    endtask

    // Called at posedge+1; the request is sampled at the next edge (E0).
    task automatic start_burst(input logic [XLEN-1:0] pc);
        snap_req = 1'b1;
        snap_pc  = pc;
        exp_burst(pc);
        @(posedge clk); #1;
        c0       = cyc - 1;
        snap_req = 1'b0;
        snap_pc  = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int mode, input int budget);
        int n;
        int ph;
        for (n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            ph = (cyc - c0) % 4;
            out_ready = (mode == 0) ? 1'b1 : (ph == 0 || ph == 3);
            if (!busy && !out_valid && exp_q.size() == 0) break;
        end
        out_ready = 1'b1;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL burst_timeout: %0d beats outstanding busy=%b required 0 and 0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; snap_req = 1'b0; snap_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({busy, rf_ren, rf_raddr, out_valid, out_idx, out_data, out_last, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b ren=%b raddr=%0d valid=%b idx=%0d data=%h last=%b drop=%0d required all 0",
                     busy, rf_ren, rf_raddr, out_valid, out_idx, out_data, out_last, drop_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        first_cyc = -1; last_cyc = -1;
        start_burst(64'h8000_0010);
        while (cyc < c0 + 35) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_c35: busy=%b required 1", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_c36: busy=%b required 0", busy);
        end
        checks++;
        if (first_cyc !== c0 + 3) begin
            errors++; $display("FAIL first_beat_cycle: cycle=%0d required %0d", first_cyc - c0, 3);
        end
`ifndef GPR_SNAP_CSR_EN
        checks++;
        if (last_cyc !== c0 + 35) begin
            errors++; $display("FAIL last_beat_cycle: cycle=%0d required %0d", last_cyc - c0, 35);
        end
`endif
        wait_done(0, 100);
    endtask

    task automatic test_drop_back_to_back;
        start_burst(64'h8000_0020);
        while (cyc < c0 + 5) begin @(posedge clk); #1; end
        snap_req = 1'b1; @(posedge clk); #1; snap_req = 1'b0;
        while (cyc < c0 + 20) begin @(posedge clk); #1; end
        snap_req = 1'b1; @(posedge clk); #1; snap_req = 1'b0;
        while (busy && cyc < c0 + 200) begin @(posedge clk); #1; end
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++; $display("FAIL drop_cnt: drop=%0d required 2", drop_cnt);
        end
        start_burst(64'h8000_0030);
        wait_done(0, 100);
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++; $display("FAIL drop_after_accept: drop=%0d required 2", drop_cnt);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        int hs_before;
        start_burst(64'h8000_0040);
        for (n = 0; n < 100; n++) begin
            if (out_valid && out_idx == 6'd10) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b drop=%0d required 0 0 0", out_valid, busy, drop_cnt);
        end
        hs_before = hs_cnt;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (hs_cnt !== hs_before) begin
            errors++; $display("FAIL beats_after_reset: %0d required 0", hs_cnt - hs_before);
        end
        start_burst(64'h8000_0050);
        wait_done(0, 100);
    endtask

    task automatic test_long_stall;
        out_ready = 1'b0;
        ren_cnt = 0;
        start_burst(64'h8000_0060);
        repeat (50) @(posedge clk); #1;
        checks++;
        if (ren_cnt > 2 || ren_cnt < 1) begin
            errors++; $display("FAIL stall_reads: reads=%0d required at most 2", ren_cnt);
        end
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL stall_head: valid=%b idx=%0d data=%h required 1 0 0", out_valid, out_idx, out_data);
        end
        wait_done(0, 100);
    endtask

    task automatic test_toggle_ready;
        ren_cnt = 0; hs_cnt = 0; max_out = 0;
        start_burst(64'h8000_0070);
        wait_done(1, 300);
        checks++;
        if (max_out > 2) begin
            errors++; $display("FAIL occupancy: outstanding=%0d required at most 2", max_out);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_drop_back_to_back();
        test_mid_reset();
        test_long_stall();
        test_toggle_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
